lift_call_scheduler: RTL and testbench
======================================

// Module: lift_call_scheduler
// PURPOSE
//  Collects floor calls from car/hall buttons and drives the target floor
//  (req_floor) of the single-car lift datapath, which steps one floor per
//  clock toward its request. It implements LOOK scheduling: serve calls
//  ahead of the car in the current direction, then reverse. It also times
//  the door-open dwell at each served floor.
// PARAMETERS
//  NUM_FLOORS    16  floors 0..NUM_FLOORS-1. Legal range 2..31, because the lift ignores requests >= 31.
//  FLOOR_W       6   width of floor numbers; matches the lift datapath.
//  DWELL_CYCLES  4   number of cycles door_open stays high per stop (>= 1).
// PORTS
//  clk           in   1           clock, rising edge
//  reset         in   1           synchronous, active-high
//  call_set      in   NUM_FLOORS  one bit per floor; a high bit registers a call
//  cur_floor     in   FLOOR_W     current floor reported by the lift (its y output)
//  lift_stop     in   1           lift stopped at its request (its stop bit 0)
//  target_floor  out  FLOOR_W     registered; drives the lift req_floor
//  pending       out  NUM_FLOORS  registered outstanding calls
//  dir_up        out  1           committed direction is up
//  dir_down      out  1           committed direction is down
//  door_open     out  1           dwell in progress
//  served        out  1           one-cycle pulse when a call is served
//  served_floor  out  FLOOR_W     floor of the last serve; held between serves
// BEHAVIOUR
//  Reset values: pending=0, target_floor=0, dir_up=0, dir_down=0, door_open=0,
//   served=0, served_floor=0. FSM state is IDLE and the dwell counter is 0.
//  Reset mid-operation drops all calls. target_floor=0 returns the car to floor 0.
//  pending is updated every cycle: pending <= (pending | call_set) & ~clr.
//   - clr is the one-hot of the floor being served in that cycle.
//   - Set and clear on the same bit in the same cycle: clear wins.
//  FSM states: IDLE, MOVE, DWELL.
//  IDLE:
//   - target_floor=cur_floor; dir_up and dir_down are both 0.
//   - pending==0: stay in IDLE.
//   - pending[cur_floor]=1: go to DWELL (serve event).
//   - Otherwise pick a direction and go to MOVE:
//     - Keep the previous direction if any pending floor lies that way.
//     - Else take the other direction. After reset, up is preferred.
//     - target_floor = the nearest pending floor in that direction.
//  MOVE:
//   - Exactly one of dir_up/dir_down is high.
//   - Each cycle, target_floor is set to the nearest pending floor f with
//     f>=cur_floor (up) or f<=cur_floor (down). This picks up calls en route.
//   - If no such floor exists, the target is held.
//   - Calls behind the car are latched but not targeted until reversal.
//   - Arrival is lift_stop=1 && cur_floor==target_floor. On arrival go to DWELL (serve event).
//  Serve event (on entry to DWELL):
//   - served=1 for exactly one cycle.
//   - served_floor=cur_floor.
//   - That pending bit is cleared.
//   - The dwell counter loads DWELL_CYCLES.
//  DWELL:
//   - door_open=1 while the counter is nonzero; the counter decrements each cycle.
//   - door_open is high for exactly DWELL_CYCLES cycles.
//   - target_floor=cur_floor; the direction is held.
//   - call_set for cur_floor during DWELL is not latched. It reloads the
//     counter to DWELL_CYCLES (door reopen); no second served pulse.
//   - When the counter expires, go to IDLE the next cycle.
//  Width rules:
//   - cur_floor >= NUM_FLOORS is treated as no match.
//   - target_floor is always < NUM_FLOORS.
//   - call_set bits above NUM_FLOORS-1 do not exist.
//  Latency: a call in cycle N at another floor, with the FSM in IDLE,
//   gives MOVE and a valid target_floor in cycle N+2.
// TESTING
//  1 Reset; call_set[5] pulse at floor 0 -> target=5, dir_up=1; lift climbs;
//    at floor 5 with stop -> served=1, served_floor=5, door_open 4 cycles,
//    pending=0, back to IDLE.
//  2 Heading to 9; call_set[4] at cur_floor=2 -> target becomes 4.
//    Serve order is 4 then 9, with two served pulses.
//  3 Moving up past 6 toward 9; call_set[3] -> target stays 9.
//    After the dwell at 9: dir_down=1, target=3, served at 3.
//  4 Idle at floor 2; call_set[2] -> DWELL directly, no movement, served_floor=2.
//  5 In DWELL at 7 with counter=1; call_set[7] -> door_open lasts 4 more
//    cycles, pending[7] stays 0, no extra served pulse.
//  6 Mid-MOVE with pending={3,7}; assert reset 1 cycle -> pending=0,
//    target=0, all outputs at reset values, FSM in IDLE.

Source files
------------

// File: rtl/lift_call_scheduler.sv
// LOOK call scheduler for a single-car lift: latches floor calls, steers the
// car's request floor and times the door dwell at each served floor.
module lift_call_scheduler #(
  parameter int NUM_FLOORS   = 16,
  parameter int FLOOR_W      = 6,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_set,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  lift_stop,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  door_open,
  output logic                  served,
  output logic [FLOOR_W-1:0]    served_floor
);

  // state | meaning
  // IDLE  | no committed direction; waiting for a call or serving one at cur_floor
  // MOVE  | car travelling in dir_up/dir_down toward target_floor
  // DWELL | door open at a served floor; counter times the dwell
  typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    last_up, last_up_nxt;
  logic [FLOOR_W-1:0]      target_nxt, served_floor_nxt;
  logic                    dir_up_nxt, dir_down_nxt, door_nxt, serve, go_up;
  logic [NUM_FLOORS-1:0]   cur_oh, call_mask, clr, pending_nxt;
  logic                    cur_valid;
  logic                    up_hit, dn_hit;
  logic [FLOOR_W-1:0]      up_f, dn_f;

  assign cur_valid = cur_floor < FLOOR_W'(NUM_FLOORS);
  assign cur_oh    = cur_valid ? (NUM_FLOORS'(1) << cur_floor) : '0;

  // Nearest pending floor at or above / at or below the car.
  always_comb begin
    up_hit = 1'b0;
    up_f   = '0;
    dn_hit = 1'b0;
    dn_f   = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) >= cur_floor)) begin
        up_hit = 1'b1;
        up_f   = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) <= cur_floor)) begin
        dn_hit = 1'b1;
        dn_f   = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_up_nxt  = last_up;
    target_nxt   = target_floor;
    dir_up_nxt   = dir_up;
    dir_down_nxt = dir_down;
    door_nxt     = 1'b0;
    serve        = 1'b0;
    go_up        = 1'b0;
    call_mask    = call_set;
    case (state)
      IDLE: begin
        dir_up_nxt   = 1'b0;
        dir_down_nxt = 1'b0;
        if (cur_valid) target_nxt = cur_floor;
        if (pending != '0) begin
          if ((pending & cur_oh) != '0) begin
            serve = 1'b1;
          end else begin
            // Keep the last direction while it still has work, else reverse.
            go_up        = last_up ? up_hit : !dn_hit;
            last_up_nxt  = go_up;
            dir_up_nxt   = go_up;
            dir_down_nxt = !go_up;
            target_nxt   = go_up ? up_f : dn_f;
            state_nxt    = MOVE;
          end
        end
      end
      MOVE: begin
        if (lift_stop && (cur_floor == target_floor)) serve = 1'b1;
        else if (dir_up && up_hit) target_nxt = up_f;
        else if (dir_down && dn_hit) target_nxt = dn_f;
      end
      DWELL: begin
        if (cur_valid) target_nxt = cur_floor;
        // A call at the open door reopens it instead of queuing a new stop.
        call_mask = call_set & ~cur_oh;
        if ((call_set & cur_oh) != '0) begin
          cnt_nxt  = CNT_W'(DWELL_CYCLES);
          door_nxt = 1'b1;
        end else if (cnt > CNT_W'(1)) begin
          cnt_nxt  = cnt - 1'b1;
          door_nxt = 1'b1;
        end else begin
          cnt_nxt      = '0;
          state_nxt    = IDLE;
          dir_up_nxt   = 1'b0;
          dir_down_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (serve) begin
      state_nxt  = DWELL;
      cnt_nxt    = CNT_W'(DWELL_CYCLES);
      door_nxt   = 1'b1;
      target_nxt = cur_floor;
    end
  end

  assign clr              = serve ? cur_oh : '0;
  assign pending_nxt      = (pending | call_mask) & ~clr;
  assign served_floor_nxt = serve ? cur_floor : served_floor;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_up      <= 1'b1;
      pending      <= '0;
      target_floor <= '0;
      dir_up       <= 1'b0;
      dir_down     <= 1'b0;
      door_open    <= 1'b0;
      served       <= 1'b0;
      served_floor <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      last_up      <= last_up_nxt;
      pending      <= pending_nxt;
      target_floor <= target_nxt;
      dir_up       <= dir_up_nxt;
      dir_down     <= dir_down_nxt;
      door_open    <= door_nxt;
      served       <= serve;
      served_floor <= served_floor_nxt;
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Closed-loop bench: a stepping-lift model follows the scheduler's target while
// a behavioural LOOK model predicts every output each cycle.
module tb_lift_call_scheduler;
  localparam int N = 16;
  localparam int W = 6;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  call_set;
  logic [W-1:0]  cur_floor;
  logic          lift_stop;
  logic [W-1:0]  target_floor;
  logic [N-1:0]  pending;
  logic          dir_up, dir_down, door_open, served;
  logic [W-1:0]  served_floor;

  lift_call_scheduler #(.NUM_FLOORS(N), .FLOOR_W(W), .DWELL_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .call_set(call_set), .cur_floor(cur_floor),
    .lift_stop(lift_stop), .target_floor(target_floor), .pending(pending),
    .dir_up(dir_up), .dir_down(dir_down), .door_open(door_open),
    .served(served), .served_floor(served_floor)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int car = 0;

  // model state: mode 0 idle, 1 travelling, 2 door dwell
  bit [N-1:0] m_pending = '0;
  int m_target = 0, m_sfloor = 0, m_mode = 0, m_cnt = 0;
  bit m_up = 0, m_down = 0, m_door = 0, m_served = 0, m_pref_up = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // nearest pending floor from cur in the given direction (inclusive), -1 if none
  function automatic int nearest(input bit [N-1:0] p, input int cur, input bit up);
    if (up) begin
      for (int f = cur; f < N; f++) if (p[f]) return f;
    end else begin
      for (int f = cur; f >= 0; f--) if (p[f]) return f;
    end
    return -1;
  endfunction

  task automatic model_update(input bit rst, input bit [N-1:0] calls, input int cur, input bit stop);
    bit srv = 0;
    bit go;
    bit [N-1:0] oh = N'(1) << cur;
    bit [N-1:0] latch = calls;
    int nf;
    if (rst) begin
      m_pending = '0; m_target = 0; m_sfloor = 0; m_mode = 0; m_cnt = 0;
      m_up = 0; m_down = 0; m_door = 0; m_served = 0; m_pref_up = 1;
      return;
    end
    m_door = 0;
    if (m_mode == 0) begin
      m_target = cur; m_up = 0; m_down = 0;
      if (m_pending != 0) begin
        if (m_pending[cur]) srv = 1;
        else begin
          go = m_pref_up ? (nearest(m_pending, cur, 1) >= 0) : !(nearest(m_pending, cur, 0) >= 0);
          m_pref_up = go;
          m_up = go; m_down = !go;
          m_target = nearest(m_pending, cur, go);
          m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (stop && cur == m_target) srv = 1;
      else begin
        nf = nearest(m_pending, cur, m_up);
        if (nf >= 0) m_target = nf;
      end
    end else begin
      m_target = cur;
      latch = calls & ~oh;
      if (calls[cur]) begin m_cnt = D; m_door = 1; end
      else if (m_cnt > 1) begin m_cnt--; m_door = 1; end
      else begin m_cnt = 0; m_mode = 0; m_up = 0; m_down = 0; end
    end
    m_pending = m_pending | latch;
    if (srv) begin
      m_pending = m_pending & ~oh;
      m_mode = 2; m_cnt = D; m_door = 1; m_sfloor = cur; m_target = cur;
    end
    m_served = srv;
  endtask

  task automatic step(input logic [N-1:0] calls, input bit rst);
    int old_t = m_target;
    bit stop = (car == m_target);
    call_set = calls;
    reset = rst;
    cur_floor = car[W-1:0];
    lift_stop = stop;
    @(posedge clk);
    model_update(rst, calls, car, stop);
    if (car < old_t) car++;
    else if (car > old_t) car--;
    #1;
  endtask

  task automatic call(input int f);
    logic [N-1:0] c = '0;
    c[f] = 1'b1;
    step(c, 0);
  endtask

  task automatic wait_serve(input int f, input string name);
    int n = 0;
    do begin step('0, 0); n++; end while (!served && n < 200);
    if (!served) chk({name, "_timeout"}, 0, 1);
    else chk(name, served_floor, f);
  endtask

  task automatic wait_car(input int f);
    int n = 0;
    while (car != f && n < 200) begin step('0, 0); n++; end
    if (car != f) chk("wait_car_timeout", car, f);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("target_floor", target_floor, m_target);
      chk("pending", pending, m_pending);
      chk("dir_up", dir_up, m_up);
      chk("dir_down", dir_down, m_down);
      chk("door_open", door_open, m_door);
      chk("served", served, m_served);
      chk("served_floor", served_floor, m_sfloor);
    end
  end

  initial begin
    int dc, sc, k;
    logic [N-1:0] c;
    call_set = '0; reset = 1'b1; cur_floor = '0; lift_stop = 1'b1;
    step('0, 1);
    step('0, 1);
    chk_en = 1'b1;
    chk("rst_pending", pending, 0);
    chk("rst_target", target_floor, 0);

    // basic call to 5 from floor 0
    call(5);
    step('0, 0);
    chk("t1_target", target_floor, 5);
    chk("t1_dir_up", dir_up, 1);
    wait_serve(5, "t1_served_floor");
    dc = door_open; k = 0;
    while (door_open && k < 20) begin step('0, 0); if (door_open) dc++; k++; end
    chk("t1_door_cycles", dc, 4);
    chk("t1_pending", pending, 0);
    chk("t1_dir_idle", dir_up | dir_down, 0);

    // call at the idle car's floor, then reopen the door at counter 1
    call(5);
    wait_serve(5, "t4_served_floor");
    chk("t4_no_move", target_floor, 5);
    dc = door_open; sc = 0;
    repeat (3) begin step('0, 0); dc += door_open; sc += served; end
    call(5); dc += door_open; sc += served;
    k = 0;
    while (door_open && k < 20) begin step('0, 0); dc += door_open; sc += served; k++; end
    chk("t5_door_cycles", dc, 8);
    chk("t5_extra_served", sc, 0);
    chk("t5_pending", pending, 0);

    // en-route pickup: heading to 9, call 4 from floor 2
    call(0);
    wait_serve(0, "t2_home");
    call(9);
    wait_car(2);
    call(4);
    step('0, 0);
    chk("t2_retarget", target_floor, 4);
    wait_serve(4, "t2_first");
    wait_serve(9, "t2_second");

    // call behind the car is deferred until reversal
    call(0);
    wait_serve(0, "t3_home");
    call(9);
    wait_car(7);
    call(3);
    step('0, 0);
    chk("t3_target_kept", target_floor, 9);
    wait_serve(9, "t3_first");
    wait_serve(3, "t3_second");
    chk("t3_dir_down", dir_down, 1);

    // reset in the middle of a move
    call(7);
    wait_car(5);
    call(3);
    chk("t6_pending_before", pending, 16'h0088);
    step('0, 1);
    chk("t6_pending", pending, 0);
    chk("t6_target", target_floor, 0);
    chk("t6_dirs", dir_up | dir_down, 0);
    chk("t6_door", door_open, 0);
    chk("t6_served", served, 0);
    chk("t6_served_floor", served_floor, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      c = '0;
      if ($urandom_range(3) == 0) c[$urandom_range(N - 1)] = 1'b1;
      if ($urandom_range(19) == 0) c = N'($urandom);
      step(c, $urandom_range(599) == 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
